// File: rtl/pipelined_addsub_pkg.sv
// Shared widths and result record for the pipelined add/subtract unit.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package pipelined_addsub_pkg;

    localparam int ADDSUB_WIDTH  = 16;
    localparam int ADDSUB_STAGES = 4;

    typedef struct packed {
        logic [ADDSUB_WIDTH-1:0] s;
        logic                    c_out;
        logic                    ovf;
    } addsub_res_t;

endpackage

// File: rtl/pipelined_addsub_if.sv
// Operand and result handshake bundle for pipelined_addsub.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the operand and the result side.
interface pipelined_addsub_if #(
    parameter int W = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         c_out;
    logic         ovf;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, s, c_out, ovf
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, s, c_out, ovf
    );
endinterface

// File: rtl/pipelined_addsub_chunk.sv
// One chunk of the carry chain: ripple of CHUNK_W full adders.
// Latency: combinational.
// Backpressure: none.
module addsub_chunk #(
    parameter int CHUNK_W = 4
) (
    input  logic [CHUNK_W-1:0] i_a,
    input  logic [CHUNK_W-1:0] i_b,
    input  logic               i_c_in,
    output logic [CHUNK_W-1:0] o_s,
    output logic               o_c_out,
    output logic               o_c_msb_in
);
    logic [CHUNK_W:0] w_c;

    assign w_c[0] = i_c_in;

    for (genvar i = 0; i < CHUNK_W; i++) begin : g_fa
        assign o_s[i]     = i_a[i] ^ i_b[i] ^ w_c[i];
        assign w_c[i + 1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
    end

    assign o_c_out    = w_c[CHUNK_W];
    assign o_c_msb_in = w_c[CHUNK_W-1];
endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract; the carry chain is cut into NUM_STAGES registered chunks.
// Latency: NUM_STAGES edges from the accepting edge to out_valid; 1 op/cycle.
// Backpressure: in_ready = !out_valid | out_ready; the whole pipe holds when low.
module pipelined_addsub
    import pipelined_addsub_pkg::*;
#(
    parameter int BIT_WIDTH  = ADDSUB_WIDTH,
    parameter int NUM_STAGES = ADDSUB_STAGES
) (
    input logic               clk,
    input logic               rst_n,
    pipelined_addsub_if.slave bus
);
    localparam int CHUNK_W = BIT_WIDTH / NUM_STAGES;

    if (NUM_STAGES < 1 || (BIT_WIDTH % NUM_STAGES) != 0) begin : g_bad_cfg
        $error("pipelined_addsub: BIT_WIDTH must be a non-zero multiple of NUM_STAGES");
    end

    logic w_adv;

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        localparam int LO    = k * CHUNK_W;
        localparam int REM_W = BIT_WIDTH - LO;

        logic                 w_v_in;
        logic                 w_c_in;
        logic [BIT_WIDTH-1:0] w_x_in;
        logic [REM_W-1:0]     w_b_in;
        logic [CHUNK_W-1:0]   w_s;
        logic                 w_c;
        logic                 w_c_msb;
        logic [BIT_WIDTH-1:0] w_x_nxt;

        // r_x holds finished sum chunks below LO+CHUNK_W and untouched a chunks above
        logic                 r_vld;
        logic [BIT_WIDTH-1:0] r_x;
        logic                 r_c;

        if (k == 0) begin : g_src
            assign w_v_in = bus.in_valid;
            assign w_c_in = bus.sub;
            assign w_x_in = bus.a;
            assign w_b_in = bus.sub ? ~bus.b : bus.b;
        end else begin : g_src
            assign w_v_in = g_stage[k-1].r_vld;
            assign w_c_in = g_stage[k-1].r_c;
            assign w_x_in = g_stage[k-1].r_x;
            assign w_b_in = g_stage[k-1].g_skew.r_bh;
        end

        addsub_chunk #(.CHUNK_W(CHUNK_W)) u_chunk (
            .i_a        (w_x_in[LO +: CHUNK_W]),
            .i_b        (w_b_in[CHUNK_W-1:0]),
            .i_c_in     (w_c_in),
            .o_s        (w_s),
            .o_c_out    (w_c),
            .o_c_msb_in (w_c_msb)
        );

        always_comb begin
            w_x_nxt                = w_x_in;
            w_x_nxt[LO +: CHUNK_W] = w_s;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_vld <= 1'b0;
                r_x   <= '0;
                r_c   <= 1'b0;
            end else if (w_adv) begin
                r_vld <= w_v_in;
                r_x   <= w_x_nxt;
                r_c   <= w_c;
            end
        end

        if (REM_W > CHUNK_W) begin : g_skew
            logic [REM_W-CHUNK_W-1:0] r_bh;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_bh <= '0;
                end else if (w_adv) begin
                    r_bh <= w_b_in[REM_W-1:CHUNK_W];
                end
            end
        end

        if (k == NUM_STAGES - 1) begin : g_last
            logic r_ovf;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ovf <= 1'b0;
                end else if (w_adv) begin
                    r_ovf <= w_c_msb ^ w_c;
                end
            end
        end
    end

    assign w_adv         = !g_stage[NUM_STAGES-1].r_vld || bus.out_ready;
    assign bus.in_ready  = w_adv;
    assign bus.out_valid = g_stage[NUM_STAGES-1].r_vld;
    assign bus.s         = g_stage[NUM_STAGES-1].r_x;
    assign bus.c_out     = g_stage[NUM_STAGES-1].r_c;
    assign bus.ovf       = g_stage[NUM_STAGES-1].g_last.r_ovf;
endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed bench for pipelined_addsub with a result scoreboard.
// Latency: checks NUM_STAGES-edge latency and consecutive-cycle throughput.
// Backpressure: exercises stall, release and reset with operations in flight.
`timescale 1ns/1ps
module tb_pipelined_addsub;
    import pipelined_addsub_pkg::*;

    localparam int W = ADDSUB_WIDTH;
    localparam int N = ADDSUB_STAGES;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    addsub_res_t sb[$];
    int          out_cyc[$];
    addsub_res_t mon_exp;
    logic [W-1:0] pa, pb;
    int          base;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pipelined_addsub_if #(.W(W)) bus ();

    pipelined_addsub #(.BIT_WIDTH(W), .NUM_STAGES(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic addsub_res_t mk(input logic [W-1:0] s, input logic c, input logic o);
        addsub_res_t r;
        r.s = s; r.c_out = c; r.ovf = o;
        return r;
    endfunction

    function automatic addsub_res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        addsub_res_t r;
        logic [W:0]  wide;
        if (sub) begin
            wide    = {1'b0, a} - {1'b0, b};
            r.c_out = (a >= b);
            r.ovf   = (a[W-1] != b[W-1]) && (wide[W-1] != a[W-1]);
        end else begin
            wide    = {1'b0, a} + {1'b0, b};
            r.c_out = wide[W];
            r.ovf   = (a[W-1] == b[W-1]) && (wide[W-1] != a[W-1]);
        end
        r.s = wide[W-1:0];
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            out_cyc.push_back(cyc);
            n_tests++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_out: got s=%0h expected no result", bus.s);
            end
            if (sb.size() != 0) begin
                mon_exp = sb.pop_front();
                chk("out_s", bus.s, mon_exp.s);
                chk("out_c_out", bus.c_out, mon_exp.c_out);
                chk("out_ovf", bus.ovf, mon_exp.ovf);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the accepting edge with in_valid still high.
    task automatic send_exp(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                            input addsub_res_t exp);
        logic rdy;
        bit   done;
        done = 0;
        bus.in_valid = 1'b1; bus.a = a; bus.b = b; bus.sub = sub;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            rdy = bus.in_ready;
            @(posedge clk);
            if (rdy && rst_n) begin
                sb.push_back(exp);
                done = 1;
            end
            #1;
        end
        n_tests++;
        assert (done) else begin
            n_fail++;
            $error("FAIL accept_timeout: got no accept expected accept within 100 cycles");
        end
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        send_exp(a, b, sub, model(a, b, sub));
    endtask

    // Counts edges from the accepting edge (edge 1) until out_valid is seen.
    task automatic wait_out(input string tag);
        int lat;
        bit seen;
        lat = 1; seen = 0;
        while (!seen && lat < 20) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1;
            else begin
                @(posedge clk);
                lat++;
            end
        end
        chk(tag, lat, N);
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        chk("drain_empty", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.sub = 1'b0; bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_s", bus.s, 0);
        chk("rst_c_out", bus.c_out, 0);
        chk("rst_ovf", bus.ovf, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", bus.in_ready, 1);

        // Single op and latency
        send_exp(16'h1234, 16'h0FF1, 1'b0, mk(16'h2225, 1'b0, 1'b0));
        bus.in_valid = 1'b0;
        wait_out("lat_single");
        drain();

        // Wrap, signed overflow and subtract corners, back to back
        send_exp(16'hFFFF, 16'h0001, 1'b0, mk(16'h0000, 1'b1, 1'b0));
        send_exp(16'h7FFF, 16'h0001, 1'b0, mk(16'h8000, 1'b0, 1'b1));
        send_exp(16'h0005, 16'h0007, 1'b1, mk(16'hFFFE, 1'b0, 1'b0));
        send_exp(16'h8000, 16'h0001, 1'b1, mk(16'h7FFF, 1'b1, 1'b1));
        send_exp(16'h1234, 16'h1234, 1'b1, mk(16'h0000, 1'b1, 1'b0));
        bus.in_valid = 1'b0;
        drain();

        // Mixed stream at full rate
        base = out_cyc.size();
        for (int i = 0; i < 8; i++) begin
            pa = W'($urandom_range(0, 16'hFFFF));
            pb = W'($urandom_range(0, 16'hFFFF));
            send(pa, pb, i[0]);
        end
        bus.in_valid = 1'b0;
        drain();
        chk("b2b_count", out_cyc.size() - base, 8);
        if (out_cyc.size() >= base + 8)
            chk("b2b_consecutive", out_cyc[base+7] - out_cyc[base], 7);

        // Backpressure with the pipe full
        base = out_cyc.size();
        bus.out_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            pa = W'($urandom_range(0, 16'hFFFF));
            pb = W'($urandom_range(0, 16'hFFFF));
            send(pa, pb, i[0]);
        end
        pa = 16'h4321; pb = 16'hF00D;
        bus.a = pa; bus.b = pb; bus.sub = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("stall_in_ready", bus.in_ready, 0);
            chk("stall_out_valid", bus.out_valid, 1);
            chk("stall_s", bus.s, sb[0].s);
            chk("stall_c_out", bus.c_out, sb[0].c_out);
            chk("stall_ovf", bus.ovf, sb[0].ovf);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        send(pa, pb, 1'b1);
        bus.in_valid = 1'b0;
        drain();
        chk("stall_count", out_cyc.size() - base, N + 1);

        // Reset with three operations in flight
        bus.out_ready = 1'b0;
        send(16'h0100, 16'h0200, 1'b0);
        send(16'h0300, 16'h0001, 1'b1);
        send(16'hAAAA, 16'h5555, 1'b0);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("pre_rst_out_valid", bus.out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", bus.out_valid, 0);
        chk("async_rst_s", bus.s, 0);
        chk("async_rst_in_ready", bus.in_ready, 1);
        sb.delete();
        base = out_cyc.size();
        @(posedge clk);
        #1;
        chk("rst_hold_out_valid", bus.out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("no_stale", out_cyc.size() - base, 0);
        send_exp(16'h0F0F, 16'h00F1, 1'b0, mk(16'h1000, 1'b0, 1'b0));
        bus.in_valid = 1'b0;
        wait_out("lat_after_rst");
        drain();
        chk("after_rst_count", out_cyc.size() - base, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
